memz_stage_seq: RTL and testbench
=================================

# memz_stage_seq

Stage sequencer that drives the read- and write-side stage buses consumed by the MEMZ control logic (rd_stage, rd_lstep, wr_stage, wr_lstep). On a start request it steps the read side through stages 0..9, each lasting a programmable number of steps. It replays the same stage/last-step sequence on the write side after a fixed datapath latency, then reports completion. It sits between the layer controller (start/abort/done) and the MEMZ/datapath control blocks.

## Interface
- STEPW, default 8: width of step counter and step_len.
- WR_LAT, default 3: cycles from a read-side step to the matching write-side step; legal range ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after rst.
- step_len  in  STEPW  steps per stage; latched on accepted start; value 0 is treated as 1.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- rd_valid  out  1  read-side step active.
- rd_stage  out  4  read stage 0..9; 4'hF when rd_valid=0.
- rd_step  out  STEPW  step index within stage; 0 when idle.
- rd_lstep  out  1  last step of current read stage; 0 when rd_valid=0.
- wr_valid, wr_stage[3:0], wr_lstep  out  write-side copies, delayed by exactly WR_LAT cycles; same idle values (0, 4'hF, 0).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 latches len_m1 = max(step_len,1)-1 and moves to RUN. The next cycle drives rd_stage=0, rd_step=0.
- RUN: each cycle emits one read step. rd_lstep=(rd_step==len_m1). After an lstep cycle, rd_step returns to 0 and rd_stage increments. After the lstep of stage 9, go to DRAIN; rd_valid drops.
- DRAIN: wait until the delay line is empty (last write-side step emitted). Next cycle: done=1, state IDLE.
- Write side: a WR_LAT-deep shift of {rd_valid, rd_stage, rd_lstep}. The wr_* outputs are the tail entry; when tail valid=0, outputs are forced to idle values.
- start while busy or during the done cycle's FSM-not-idle states: ignored. start in the done cycle (FSM already IDLE): accepted.
- abort in RUN/DRAIN: next cycle FSM=IDLE, delay line flushed (all wr_* idle), no done pulse. abort in IDLE: no effect. abort and start in the same IDLE cycle: abort wins, no run.
- step_len changes mid-run have no effect (latched value used).
- Counters: rd_stage 4-bit saturating at 9 by FSM exit, never wraps; rd_step STEPW-bit, never exceeds len_m1.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_stage=4'hF, rd_step=0, rd_lstep=0, wr_valid=0, wr_stage=4'hF, wr_lstep=0; FSM=IDLE, delay line empty.
- Reset mid-run: immediate return to reset values; no done.
- Start sampled at edge T (L = effective step_len): first read step at T+1, busy=1 from T+1. Last rd_lstep (stage 9) at T+10L.
- Write-side step at cycle c+WR_LAT for every read step at c. The last wr_lstep is at T+10L+WR_LAT; busy is high through this cycle.
- done=1 and busy=0 at T+10L+WR_LAT+1. Total start-to-done latency: 10L+WR_LAT+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package memz_pkg: STAGE_LAST=4'd9, STAGE_IDLE=4'hF, FSM state encoding (IDLE/RUN/DRAIN).
- Sub-module stage_delay_line: parameterised (DEPTH=WR_LAT, WIDTH=6) shift register with asynchronous reset and synchronous flush; it produces the wr_* outputs.

## Test plan
- step_len=1, WR_LAT=3, start at T: rd_stage 0..9 on T+1..T+10, rd_lstep high every cycle; wr_stage 0..9 on T+4..T+13; done at T+14.
- step_len=4: each rd_stage held 4 cycles with rd_step 0,1,2,3 and rd_lstep on step 3; last rd_lstep at T+40; done at T+44.
- step_len=0: behaves identically to step_len=1 (done at T+14).
- start pulsed at T+5 during a run: ignored, no timing change. start in the done cycle: new run begins next cycle with rd_stage=0.
- abort at T+6 (step_len=2): next cycle all rd_*/wr_* at idle values, busy=0, no done pulse ever.
- rst asserted asynchronously mid-DRAIN: outputs at reset values immediately. A later start (step_len=1) completes normally with done 14 cycles after start.

Source files
------------

// File: rtl/memz_pkg.sv
// Shared constants and types for the MEMZ stage sequencer.
package memz_pkg;

  localparam logic [3:0] STAGE_LAST = 4'd9;
  localparam logic [3:0] STAGE_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // One step as seen by the write side; idle entries carry the bus idle values.
  typedef struct packed {
    logic       valid;
    logic [3:0] stage;
    logic       lstep;
  } step_ent_t;

  localparam int        ENT_W    = $bits(step_ent_t);
  localparam step_ent_t ENT_IDLE = '{valid: 1'b0, stage: STAGE_IDLE, lstep: 1'b0};

endpackage

// File: rtl/memz_stage_seq_if.sv
// Controller-facing and MEMZ-facing signal bundle of the stage sequencer.
interface memz_stage_seq_if #(
  parameter int STEPW = 8
);
  logic             start;
  logic             abort;
  logic [STEPW-1:0] step_len;
  logic             busy;
  logic             done;
  logic             rd_valid;
  logic [3:0]       rd_stage;
  logic [STEPW-1:0] rd_step;
  logic             rd_lstep;
  logic             wr_valid;
  logic [3:0]       wr_stage;
  logic             wr_lstep;

  modport master (
    output start, abort, step_len,
    input  busy, done, rd_valid, rd_stage, rd_step, rd_lstep,
           wr_valid, wr_stage, wr_lstep
  );

  modport slave (
    input  start, abort, step_len,
    output busy, done, rd_valid, rd_stage, rd_step, rd_lstep,
           wr_valid, wr_stage, wr_lstep
  );
endinterface

// File: rtl/stage_delay_line.sv
// Fixed-depth shift register replaying read-side steps onto the write side.
module stage_delay_line #(
  parameter int               DEPTH    = 3,
  parameter int               WIDTH    = 6,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= {DEPTH{IDLE_VAL}};
    end else if (i_flush) begin
      r_sr <= {DEPTH{IDLE_VAL}};
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/memz_stage_seq.sv
// Stage sequencer: walks read stages 0..9 at a programmable step count,
// replays them on the write side WR_LAT cycles later, then pulses done.
module memz_stage_seq
  import memz_pkg::*;
#(
  parameter int STEPW  = 8,
  parameter int WR_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  memz_stage_seq_if.slave   bus
);

  seq_state_e       r_state, w_nxt_state;
  logic [STEPW-1:0] r_len_m1, w_len_in;
  logic             r_rd_valid, w_nxt_valid;
  logic [3:0]       r_rd_stage, w_nxt_stage;
  logic [STEPW-1:0] r_rd_step, w_nxt_step, w_step_inc;
  logic             r_rd_lstep, w_nxt_lstep;
  logic             r_busy, r_done, w_nxt_done;
  logic             w_start_ok, w_flush, w_last_rd, w_last_wr;
  step_ent_t        w_rd_ent, w_tail;

  // A zero step count behaves as a single step per stage.
  assign w_len_in   = (bus.step_len == '0) ? '0 : bus.step_len - STEPW'(1);
  assign w_step_inc = r_rd_step + STEPW'(1);
  assign w_start_ok = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_flush    = bus.abort && (r_state != ST_IDLE);
  assign w_last_rd  = r_rd_valid && r_rd_lstep && (r_rd_stage == STAGE_LAST);
  assign w_last_wr  = w_tail.valid && w_tail.lstep && (w_tail.stage == STAGE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok)    w_nxt_state = ST_RUN;
      ST_RUN:   if (bus.abort)     w_nxt_state = ST_IDLE;
                else if (w_last_rd) w_nxt_state = ST_DRAIN;
      ST_DRAIN: if (bus.abort || w_last_wr) w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_valid = 1'b0;
    w_nxt_stage = STAGE_IDLE;
    w_nxt_step  = '0;
    w_nxt_lstep = 1'b0;
    w_nxt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_nxt_valid = 1'b1;
          w_nxt_stage = 4'd0;
          w_nxt_lstep = (w_len_in == '0);
        end
      end
      ST_RUN: begin
        if (!bus.abort && !w_last_rd) begin
          w_nxt_valid = 1'b1;
          if (r_rd_lstep) begin
            w_nxt_stage = r_rd_stage + 4'd1;
            w_nxt_lstep = (r_len_m1 == '0);
          end else begin
            w_nxt_stage = r_rd_stage;
            w_nxt_step  = w_step_inc;
            w_nxt_lstep = (w_step_inc == r_len_m1);
          end
        end
      end
      ST_DRAIN: w_nxt_done = !bus.abort && w_last_wr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_m1   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_stage <= STAGE_IDLE;
      r_rd_step  <= '0;
      r_rd_lstep <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start_ok) r_len_m1 <= w_len_in;
      r_rd_valid <= w_nxt_valid;
      r_rd_stage <= w_nxt_stage;
      r_rd_step  <= w_nxt_step;
      r_rd_lstep <= w_nxt_lstep;
      r_busy     <= (w_nxt_state != ST_IDLE);
      r_done     <= w_nxt_done;
    end
  end

  assign w_rd_ent = '{valid: r_rd_valid, stage: r_rd_stage, lstep: r_rd_lstep};

  stage_delay_line #(
    .DEPTH    (WR_LAT),
    .WIDTH    (ENT_W),
    .IDLE_VAL (ENT_IDLE)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_d     (w_rd_ent),
    .o_q     (w_tail)
  );

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_stage = r_rd_stage;
  assign bus.rd_step  = r_rd_step;
  assign bus.rd_lstep = r_rd_lstep;
  assign bus.wr_valid = w_tail.valid;
  assign bus.wr_stage = w_tail.valid ? w_tail.stage : STAGE_IDLE;
  assign bus.wr_lstep = w_tail.valid && w_tail.lstep;

endmodule

// File: tb/tb_memz_stage_seq.sv
// Scoreboard bench for memz_stage_seq: stimulus queues expected steps, a negedge monitor checks them.
module tb_memz_stage_seq;
  localparam int STEPW  = 8;
  localparam int WR_LAT = 3;

  typedef struct {
    int cyc;
    int stage;
    int step;
    bit lstep;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  exp_t rd_q[$];
  exp_t wr_q[$];
  int   done_q[$];

  memz_stage_seq_if #(.STEPW(STEPW)) bus ();

  memz_stage_seq #(.STEPW(STEPW), .WR_LAT(WR_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input string msg);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s @cyc %0d: %s", nm, cyc, msg);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push the expected step stream; entries visible after cycle cut are dropped.
  task automatic run_exp(input int s, input int l, input int a);
    int cut;
    cut = (a == 0) ? 32'h7fff_ffff : s + a;
    for (int k = 0; k < 10 * l; k++) begin
      exp_t e;
      e.cyc = s + 1 + k; e.stage = k / l; e.step = k % l; e.lstep = ((k % l) == l - 1);
      if (e.cyc <= cut) rd_q.push_back(e);
      e.cyc = e.cyc + WR_LAT;
      if (e.cyc <= cut) wr_q.push_back(e);
    end
    if (a == 0) done_q.push_back(s + 10 * l + WR_LAT + 1);
    busy_lo = s + 1;
    busy_hi = (a == 0) ? s + 10 * l + WR_LAT : s + a;
  endtask

  task automatic issue(input int len, input int a, output int s);
    s = cyc;
    bus.step_len = STEPW'(len);
    bus.start = 1'b1;
    run_exp(s, (len == 0) ? 1 : len, a);
    go_to(s + 1);
    bus.start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(bus.busy == 0 && bus.done == 0 && bus.rd_valid == 0 && bus.rd_stage == 4'hF &&
        bus.rd_step == 0 && bus.rd_lstep == 0 && bus.wr_valid == 0 && bus.wr_stage == 4'hF &&
        bus.wr_lstep == 0, nm,
        $sformatf("got busy=%b done=%b rv=%b rs=%h rstep=%0d rl=%b wv=%b ws=%h wl=%b, want 0 0 0 f 0 0 0 f 0",
                  bus.busy, bus.done, bus.rd_valid, bus.rd_stage, bus.rd_step, bus.rd_lstep,
                  bus.wr_valid, bus.wr_stage, bus.wr_lstep));
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) chk(1'b0, "rd_unexpected", $sformatf("got stage %0d step %0d, want none", bus.rd_stage, bus.rd_step));
      else begin
        me = rd_q.pop_front();
        chk(me.cyc == cyc && me.stage == int'(bus.rd_stage) && me.step == int'(bus.rd_step) && me.lstep == bus.rd_lstep,
            "rd_step", $sformatf("got cyc %0d stage %0d step %0d lstep %b, want cyc %0d stage %0d step %0d lstep %b",
            cyc, bus.rd_stage, bus.rd_step, bus.rd_lstep, me.cyc, me.stage, me.step, me.lstep));
      end
    end else
      chk(bus.rd_stage == 4'hF && bus.rd_step == 0 && bus.rd_lstep == 0, "rd_idle",
          $sformatf("got stage %h step %0d lstep %b, want f 0 0", bus.rd_stage, bus.rd_step, bus.rd_lstep));
    if (bus.wr_valid) begin
      if (wr_q.size() == 0) chk(1'b0, "wr_unexpected", $sformatf("got stage %0d, want none", bus.wr_stage));
      else begin
        me = wr_q.pop_front();
        chk(me.cyc == cyc && me.stage == int'(bus.wr_stage) && me.lstep == bus.wr_lstep,
            "wr_step", $sformatf("got cyc %0d stage %0d lstep %b, want cyc %0d stage %0d lstep %b",
            cyc, bus.wr_stage, bus.wr_lstep, me.cyc, me.stage, me.lstep));
      end
    end else
      chk(bus.wr_stage == 4'hF && bus.wr_lstep == 0, "wr_idle",
          $sformatf("got stage %h lstep %b, want f 0", bus.wr_stage, bus.wr_lstep));
    if (bus.done) begin
      if (done_q.size() == 0) chk(1'b0, "done_unexpected", "got done=1, want 0");
      else begin
        int dc;
        dc = done_q.pop_front();
        chk(dc == cyc, "done_cycle", $sformatf("got done at %0d, want %0d", cyc, dc));
      end
    end
    chk(bus.busy == (cyc >= busy_lo && cyc <= busy_hi), "busy",
        $sformatf("got %b, want %b", bus.busy, (cyc >= busy_lo && cyc <= busy_hi)));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.step_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_state");
    rst = 1'b0;
    go_to(cyc + 2);

    // L=1, then a new run started in the done cycle with L=4
    issue(1, 0, s);
    go_to(s + 14);
    issue(4, 0, s);
    bus.step_len = 8'd7;            // must not affect the latched length
    go_to(s + 5);
    bus.start = 1'b1;               // ignored while busy
    go_to(s + 6);
    bus.start = 1'b0;
    go_to(s + 47);

    // step_len 0 acts as 1
    issue(0, 0, s);
    go_to(s + 16);

    // abort at T+6 with L=2
    issue(2, 6, s);
    go_to(s + 6);
    bus.abort = 1'b1;
    go_to(s + 7);
    bus.abort = 1'b0;
    chk_reset_vals("abort_idle");
    go_to(s + 30);

    // abort alone in idle, then abort+start together: neither starts a run
    bus.abort = 1'b1;
    go_to(cyc + 1);
    bus.start = 1'b1;
    bus.step_len = 8'd3;
    go_to(cyc + 1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    go_to(cyc + 20);

    // async reset mid-DRAIN, then a clean L=1 run
    issue(1, 11, s);
    go_to(s + 12);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    go_to(s + 14);
    rst = 1'b0;
    go_to(s + 16);
    issue(1, 0, s);
    go_to(s + 18);

    chk(rd_q.size() == 0, "rd_leftover", $sformatf("got %0d pending, want 0", rd_q.size()));
    chk(wr_q.size() == 0, "wr_leftover", $sformatf("got %0d pending, want 0", wr_q.size()));
    chk(done_q.size() == 0, "done_leftover", $sformatf("got %0d pending, want 0", done_q.size()));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
